// File: rtl/mm_front_end.sv
// Memory-mapped coprocessor front end: streams a linear block of words from the
// local input memory into the actor input port through a 2-entry output buffer.
module mm_front_end #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int SIZE_W = 11
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_send,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              done,
  output logic              empty
);

  localparam logic [SIZE_W-1:0] MAX_WORDS = SIZE_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                done_s;
  logic [SIZE_W-1:0]   size_r;
  logic [SIZE_W-1:0]   size_clamp_s;
  logic [SIZE_W-1:0]   rd_cnt_r;
  logic [SIZE_W-1:0]   cons_cnt_r;
  logic [DATA_W-1:0]   buf0_r;
  logic [DATA_W-1:0]   buf1_r;
  logic [1:0]          occ_r;
  logic                infl_r;
  logic                done_r;
  logic                cons_s;
  logic                capt_s;
  logic                mem_en_s;
  logic [2:0]          pend_s;

  // Oversized requests are limited to the full memory so the address never wraps.
  assign size_clamp_s = (size > MAX_WORDS) ? MAX_WORDS : size;

  // buf0_r is always the head word, so out_data comes straight from a register.
  assign out_send = (occ_r != 2'd0);
  assign out_data = buf0_r;
  assign out_last = out_send & (cons_cnt_r == (size_r - SIZE_W'(1)));
  assign cons_s   = out_send & out_rdy;
  assign capt_s   = infl_r & (state_r == RUN) & start;

  // Words held after this edge: buffered plus landing read, minus the one leaving now.
  assign pend_s   = {1'b0, occ_r} + {2'b00, infl_r} - {2'b00, cons_s};
  assign mem_en_s = (state_r == RUN) & start & (rd_cnt_r < size_r) & (pend_s < 3'd2);

  assign mem_en   = mem_en_s;
  assign mem_addr = rd_cnt_r[ADDR_W-1:0];
  assign done     = done_r;
  assign empty    = (state_r != RUN);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and done-pulse request.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (size_clamp_s == {SIZE_W{1'b0}}) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!start) begin
          state_s = IDLE;
        end else if (cons_s & out_last) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (!start) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Counters, in-flight flag and the head-first two-entry buffer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      size_r     <= {SIZE_W{1'b0}};
      rd_cnt_r   <= {SIZE_W{1'b0}};
      cons_cnt_r <= {SIZE_W{1'b0}};
      buf0_r     <= {DATA_W{1'b0}};
      buf1_r     <= {DATA_W{1'b0}};
      occ_r      <= 2'd0;
      infl_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= done_s;
      if ((state_r == IDLE) && start) begin
        size_r     <= size_clamp_s;
        rd_cnt_r   <= {SIZE_W{1'b0}};
        cons_cnt_r <= {SIZE_W{1'b0}};
        occ_r      <= 2'd0;
        infl_r     <= 1'b0;
      end else if ((state_r == RUN) && !start) begin
        occ_r  <= 2'd0;
        infl_r <= 1'b0;
      end else begin
        infl_r <= mem_en_s;
        if (mem_en_s) begin
          rd_cnt_r <= rd_cnt_r + SIZE_W'(1);
        end
        if (cons_s) begin
          cons_cnt_r <= cons_cnt_r + SIZE_W'(1);
        end
        case ({capt_s, cons_s})
          2'b10: begin
            if (occ_r == 2'd0) begin
              buf0_r <= mem_data;
            end else begin
              buf1_r <= mem_data;
            end
            occ_r <= occ_r + 2'd1;
          end
          2'b01: begin
            buf0_r <= buf1_r;
            occ_r  <= occ_r - 2'd1;
          end
          2'b11: begin
            if (occ_r == 2'd1) begin
              buf0_r <= mem_data;
            end else begin
              buf0_r <= buf1_r;
              buf1_r <= mem_data;
            end
          end
          default: begin
            occ_r <= occ_r;
          end
        endcase
      end
    end
  end

endmodule
